// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame constants
// (also used by the transmitter) and the even-parity helper.
package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   // Even parity check: nonzero when data bits plus parity bit have odd weight
   function automatic logic even_parity_err(input logic [UART_DATA_BITS-1:0] data,
                                            input logic par);
      return (^data) ^ par;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a registered
// falling-edge detector. fall_pulse is high in the same cycle that rxs first
// shows the new low level.
module uart_rx_sync (
   input  logic bclk,
   input  logic rst,
   input  logic rx_data,
   output logic rxs,
   output logic fall_pulse
);

   logic s1_r;
   logic s2_r;
   logic fall_r;

   // Synchronize the line (idle-high reset) and flag the high-to-low transition
   always_ff @(posedge bclk or negedge rst) begin
      if (!rst) begin
         s1_r   <= 1'b1;
         s2_r   <= 1'b1;
         fall_r <= 1'b0;
      end else begin
         s1_r   <= rx_data;
         s2_r   <= s1_r;
         fall_r <= s2_r & ~s1_r;
      end
   end

   assign rxs        = s2_r;
   assign fall_pulse = fall_r;

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: oversampled start-bit qualification, LSB-first data
// capture, stop-bit check and host handshake (rx_status / rd_ack / overrun).
// Optional even parity is compiled in with `define UART_RX_PARITY_EN.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DATA_BITS  = UART_DATA_BITS
) (
   input  logic                 bclk,
   input  logic                 rst,
   input  logic                 rx_en,
   input  logic                 rx_data,
   input  logic                 rd_ack,
   output logic [DATA_BITS-1:0] RBR,
   output logic                 rx_status,
   output logic                 frame_err,
   output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,output logic                 parity_err
`endif
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   // The IDLE->START transition edge counts as the first half-bit tick,
   // which puts every later sample in the middle of its bit period.
   localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 2);
   localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

   logic                 rxs;
   logic                 fall_pulse;
   rx_state_t            state_r;
   logic [TW-1:0]        tick_r;
   logic [BW-1:0]        bit_r;
   logic [DATA_BITS-1:0] shift_r;
   logic                 stop_r;
   logic                 done_r;
   logic [DATA_BITS-1:0] rbr_r;
   logic                 status_r;
   logic                 ferr_r;
   logic                 ovr_r;
`ifdef UART_RX_PARITY_EN
   logic                 par_r;
   logic                 perr_r;
`endif

   uart_rx_sync u_sync (
      .bclk       (bclk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rxs        (rxs),
      .fall_pulse (fall_pulse)
   );

   // Frame FSM: tick/bit counting, mid-bit sampling, completion strobe
   always_ff @(posedge bclk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         tick_r  <= '0;
         bit_r   <= '0;
         shift_r <= '0;
         stop_r  <= 1'b0;
         done_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_r   <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (rx_en && fall_pulse) begin
                  state_r <= START;
                  tick_r  <= '0;
               end
            end
            START: begin
               if (!rx_en) begin
                  state_r <= IDLE;
               end else if (tick_r == HALF_TICK) begin
                  tick_r <= '0;
                  bit_r  <= '0;
                  // A line that is high again at mid start bit was a glitch
                  state_r <= rxs ? IDLE : DATA;
               end else begin
                  tick_r <= tick_r + TW'(1);
               end
            end
            DATA: begin
               if (!rx_en) begin
                  state_r <= IDLE;
               end else if (tick_r == LAST_TICK) begin
                  tick_r  <= '0;
                  shift_r <= {rxs, shift_r[DATA_BITS-1:1]};
                  if (bit_r == LAST_BIT) begin
                     bit_r <= '0;
`ifdef UART_RX_PARITY_EN
                     state_r <= PARITY;
`else
                     state_r <= STOP;
`endif
                  end else begin
                     bit_r <= bit_r + BW'(1);
                  end
               end else begin
                  tick_r <= tick_r + TW'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (!rx_en) begin
                  state_r <= IDLE;
               end else if (tick_r == LAST_TICK) begin
                  tick_r  <= '0;
                  par_r   <= rxs;
                  state_r <= STOP;
               end else begin
                  tick_r <= tick_r + TW'(1);
               end
            end
`endif
            STOP: begin
               if (!rx_en) begin
                  state_r <= IDLE;
               end else if (tick_r == LAST_TICK) begin
                  tick_r  <= '0;
                  stop_r  <= rxs;
                  done_r  <= 1'b1;
                  state_r <= IDLE;
               end else begin
                  tick_r <= tick_r + TW'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               tick_r  <= '0;
               bit_r   <= '0;
            end
         endcase
      end
   end

   // Host side: load RBR and flags on completion, or drop the byte as overrun
   always_ff @(posedge bclk or negedge rst) begin
      if (!rst) begin
         rbr_r    <= '0;
         status_r <= 1'b0;
         ferr_r   <= 1'b0;
         ovr_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_r   <= 1'b0;
`endif
      end else if (done_r) begin
         // A read in the completion cycle frees RBR for the new byte
         if (!status_r || rd_ack) begin
            rbr_r    <= shift_r;
            status_r <= 1'b1;
            ferr_r   <= ~stop_r;
`ifdef UART_RX_PARITY_EN
            perr_r   <= even_parity_err(shift_r, par_r);
`endif
         end else begin
            ovr_r <= 1'b1;
         end
      end else if (rd_ack) begin
         status_r <= 1'b0;
         ovr_r    <= 1'b0;
      end else begin
         status_r <= status_r;
      end
   end

   assign RBR       = rbr_r;
   assign rx_status = status_r;
   assign frame_err = ferr_r;
   assign overrun   = ovr_r;
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_r;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver (OVERSAMPLE=16, DATA_BITS=8).
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_receiver;

   localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
   localparam int FB  = 11;
   localparam int LAT = 171;
`else
   localparam int FB  = 10;
   localparam int LAT = 155;
`endif

   logic       bclk = 1'b0;
   logic       rst = 1'b0;
   logic       rx_en = 1'b0;
   logic       rx_data = 1'b1;
   logic       rd_ack = 1'b0;
   logic [7:0] RBR;
   logic       rx_status;
   logic       frame_err;
   logic       overrun;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int rise_cyc = -1;
   logic prev_status = 1'b0;

   uart_receiver dut (
      .bclk      (bclk),
      .rst       (rst),
      .rx_en     (rx_en),
      .rx_data   (rx_data),
      .rd_ack    (rd_ack),
      .RBR       (RBR),
      .rx_status (rx_status),
      .frame_err (frame_err),
      .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
     ,.parity_err(parity_err)
`endif
   );

   always #5 bclk = ~bclk;

   always @(posedge bclk) cyc <= cyc + 1;

   always @(negedge bclk) begin
      if (rx_status && !prev_status) rise_cyc = cyc;
      prev_status = rx_status;
   end

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       ack;
      logic [7:0] e_rbr;
      logic       e_ferr;
      logic       e_ovr;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge bclk);
         #1;
      end
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] d, input logic par, input logic stop);
`ifdef UART_RX_PARITY_EN
      return {stop, par, d, 1'b0};
`else
      return {1'b1, stop, d, 1'b0} ^ {10'd0, par & 1'b0};
`endif
   endfunction

   task automatic send_bits(input logic [10:0] fr, input int n);
      for (int i = 0; i < n; i++) begin
         rx_data = fr[i];
         tick(OS);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bits(make_frame(d, ^d, stop), FB);
      rx_data = 1'b1;
   endtask

   task automatic pulse_ack();
      rd_ack = 1'b1;
      tick(1);
      rd_ack = 1'b0;
   endtask

   task automatic check_all(input string tag, input logic [7:0] e_rbr, input logic e_st,
                            input logic e_fe, input logic e_ov);
      @(negedge bclk);
      check({tag, ".RBR"}, 32'(RBR), 32'(e_rbr));
      check({tag, ".rx_status"}, 32'(rx_status), 32'(e_st));
      check({tag, ".frame_err"}, 32'(frame_err), 32'(e_fe));
      check({tag, ".overrun"}, 32'(overrun), 32'(e_ov));
      tick(1);
   endtask

   initial begin
      int t0;
      int lat;

      vecs[0] = '{8'h6C, 1'b1, 1'b1, 8'h6C, 1'b0, 1'b0};
      vecs[1] = '{8'h6D, 1'b0, 1'b1, 8'h6D, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[3] = '{8'h6C, 1'b1, 1'b1, 8'h6C, 1'b0, 1'b0};
      vecs[4] = '{8'hA5, 1'b1, 1'b0, 8'h6C, 1'b0, 1'b1};
      vecs[5] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
      vecs[6] = '{8'h3C, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
      vecs[7] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};

      // Reset state
      tick(3);
      check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      rx_en = 1'b1;
      tick(5);

      // Single byte with latency measurement
      t0 = cyc;
      send_frame(8'h6C, 1'b1);
      tick(2);
      lat = rise_cyc - t0;
      n_vec++;
      if (rise_cyc < 0 || lat < LAT - 1 || lat > LAT + 1) begin
         n_bad++;
         $display("FAIL latency: got %0d expected %0d +/-1", lat, LAT);
      end
      check_all("single", 8'h6C, 1'b1, 1'b0, 1'b0);
`ifdef UART_RX_PARITY_EN
      @(negedge bclk);
      check("single.parity_err", 32'(parity_err), 32'd0);
      tick(1);
`endif

      // Table of frames with optional read before each
      for (int v = 0; v < 8; v++) begin
         if (vecs[v].ack) begin
            pulse_ack();
            @(negedge bclk);
            check($sformatf("v%0d.ack_status", v), 32'(rx_status), 32'd0);
            check($sformatf("v%0d.ack_overrun", v), 32'(overrun), 32'd0);
            tick(1);
         end
         send_frame(vecs[v].data, vecs[v].stop);
         tick(4);
         check_all($sformatf("v%0d", v), vecs[v].e_rbr, 1'b1, vecs[v].e_ferr, vecs[v].e_ovr);
      end

      // Read in the very cycle of completion: new byte loads, no overrun
      send_bits(make_frame(8'h3C, 1'b0, 1'b1), FB - 1);
      rx_data = 1'b1;
      tick(10);
      pulse_ack();
      tick(6);
      check_all("ack_coincident", 8'h3C, 1'b1, 1'b0, 1'b0);

      // Short low glitch on idle line
      pulse_ack();
      rx_data = 1'b0;
      tick(4);
      rx_data = 1'b1;
      tick(200);
      check_all("glitch", 8'h3C, 1'b0, 1'b0, 1'b0);

      // Disable mid-frame after data bit 3
      send_bits(make_frame(8'h55, 1'b0, 1'b1), 5);
      rx_en = 1'b0;
      rx_data = 1'b1;
      tick(120);
      check_all("abort", 8'h3C, 1'b0, 1'b0, 1'b0);
      rx_en = 1'b1;
      tick(2);
      send_frame(8'h55, 1'b1);
      tick(4);
      check_all("reenable", 8'h55, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset during data bit 5
      send_bits(make_frame(8'h00, 1'b0, 1'b1), 6);
      tick(8);
      rst = 1'b0;
      #2;
      check("rst_mid.RBR", 32'(RBR), 32'd0);
      check("rst_mid.rx_status", 32'(rx_status), 32'd0);
      check("rst_mid.frame_err", 32'(frame_err), 32'd0);
      check("rst_mid.overrun", 32'(overrun), 32'd0);
      rx_data = 1'b1;
      tick(3);
      rst = 1'b1;
      tick(5);
      send_frame(8'hFF, 1'b1);
      tick(4);
      check_all("after_rst", 8'hFF, 1'b1, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
      // Wrong parity bit
      pulse_ack();
      send_bits(make_frame(8'h6C, 1'b1, 1'b1), FB);
      rx_data = 1'b1;
      tick(4);
      @(negedge bclk);
      check("bad_par.RBR", 32'(RBR), 32'h6C);
      check("bad_par.parity_err", 32'(parity_err), 32'd1);
      tick(1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel receive path of the UART. It is the counterpart of the existing transmitter.
- Samples the asynchronous serial line rx_data using a bclk that runs at OVERSAMPLE times the baud rate.
- Frame format: 1 start bit (0), 8 data bits LSB first, optional parity, 1 stop bit (1).
- Delivers each byte in RBR with a ready flag and error flags, consumed by the register/host interface.

Parameters:
- OVERSAMPLE, 16, bclk ticks per bit period; even, at least 4.
- DATA_BITS, 8, data bits per frame; RBR width.

Ports:
- bclk  input  1  receiver clock (OVERSAMPLE x baud).
- rst  input  1  asynchronous active-low reset; 0 = reset.
- rx_en  input  1  receiver enable.
- rx_data  input  1  serial line, asynchronous, idles high.
- rd_ack  input  1  one-cycle pulse; host has read RBR.
- RBR  output  DATA_BITS  received byte.
- rx_status  output  1  data ready; 1 = RBR holds an unread byte.
- frame_err  output  1  stop bit sampled 0 on last loaded byte.
- overrun  output  1  sticky; a frame completed while rx_status=1.
- parity_err  output  1  parity mismatch; present only with the macro.

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM in IDLE, counters 0, synchronizer flops 1.
- rx_data passes through a 2-flop synchronizer. All decisions use the synchronized value rxs.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: on rxs falling edge with rx_en=1, go to START and clear tick_cnt.
  - START: count OVERSAMPLE/2-1 ticks to reach mid-bit.
    - rxs=0: go to DATA, tick_cnt=0, bit_cnt=0.
    - rxs=1: glitch; return to IDLE with no flag change.
  - DATA: sample rxs every OVERSAMPLE ticks (mid-bit) into shift register, LSB first. After DATA_BITS samples go to PARITY or STOP.
  - STOP: sample at mid-bit, then go to IDLE. The next start edge is accepted from the following cycle.
- Completion, on the cycle after the stop sample:
  - rx_status=0 or rd_ack=1: load RBR; set rx_status=1; frame_err = inverted stop sample; update parity_err.
  - rx_status=1 and rd_ack=0: RBR, frame_err and parity_err unchanged; overrun set to 1; byte dropped.
- rd_ack with no completion in the same cycle: clears rx_status and overrun next cycle. RBR and error flags hold until the next load.
- rd_ack together with completion: the completion rule wins; rx_status stays 1, overrun is not set.
- rx_en deasserted mid-frame: abort to IDLE next cycle; no output changes.
- Latency: from the rx_data falling edge, rx_status rises after 2 + OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE + 1 cycles, ±1 for synchronizer phase. For OVERSAMPLE=16 with no parity this is 155 ±1.
- Counters: tick_cnt is $clog2(OVERSAMPLE) bits and wraps at OVERSAMPLE-1. bit_cnt is $clog2(DATA_BITS+1) bits.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state between DATA and STOP, sampled one bit period after the last data bit.
  - parity_err = (XOR of data bits XOR parity bit) != 0, i.e. even parity.
  - Frame is 11 bits; latency increases by OVERSAMPLE.
- Undefined: no PARITY state, no parity_err port, 10-bit frame.

Decomposition:
- Shared package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - Default OVERSAMPLE and DATA_BITS constants, shared with the transmitter.
- One sub-module, uart_rx_sync: 2-flop synchronizer plus registered falling-edge detector.
  - Outputs: rxs and fall_pulse.
  - Reset: async active-low, flops reset to 1.

Test Plan (all scenarios use OVERSAMPLE=16, no parity unless stated):
1. Single byte: send 0x6C (line: 0, 0,0,1,1,0,1,1,0, 1) -> rx_status rises 155±1 cycles after start edge; RBR=0x6C, frame_err=0, overrun=0.
2. Framing error: send 0x6D with stop bit 0 -> RBR=0x6D, rx_status=1, frame_err=1. Then send 0x00 with good stop plus rd_ack -> frame_err=0.
3. Overrun: send 0x6C, no rd_ack, then send 0xA5 -> RBR stays 0x6C, overrun=1. Pulse rd_ack -> rx_status=0 and overrun=0 next cycle.
4. Glitch / abort:
   - 4-cycle low pulse on an idle line -> no rx_status.
   - Drop rx_en after bit 3 of 0x55 -> FSM in IDLE, outputs unchanged.
   - Re-enable and send 0x55 -> RBR=0x55.
5. Reset mid-frame: assert rst=0 during data bit 5 -> all outputs 0 immediately. Release rst and send 0xFF -> RBR=0xFF, rx_status=1.
6. With UART_RX_PARITY_EN:
   - 0x6C with parity bit 0 -> parity_err=0; rx_status after 171±1 cycles.
   - 0x6C with parity bit 1 -> parity_err=1.
